// File: rtl/ofifo_deskew.sv
// Per-column output FIFOs that absorb systolic skew and pop one aligned row.
// Optional OFIFO_OVF_FLAG_EN adds a sticky o_overflow flag for dropped writes/pops.
module ofifo_deskew #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int depth   = 64
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [col*psum_bw-1:0] in,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    output logic [col*psum_bw-1:0] out,
    output logic                   o_valid,
    output logic                   o_full,
`ifdef OFIFO_OVF_FLAG_EN
    output logic                   o_overflow,
`endif
    output logic                   o_ready
);

    localparam int aw = $clog2(depth);
    localparam int pw = aw + 1;
    localparam logic [pw-1:0] depth_c = pw'(depth);
    localparam logic [pw-1:0] one_c   = pw'(1);

    logic [col-1:0]         empty;
    logic [col-1:0]         full;
    logic [col*psum_bw-1:0] rd_row;
    logic                   pop;

    assign o_valid = &(~empty);
    assign o_full  = |full;
    assign o_ready = ~o_full;
    assign pop     = rd && o_valid;

    for (genvar i = 0; i < col; i++) begin : g_col
        logic [psum_bw-1:0] mem [depth];
        logic [pw-1:0]      wptr;
        logic [pw-1:0]      rptr;
        logic [pw-1:0]      cnt;
        logic               push;

        assign cnt      = wptr - rptr;
        assign empty[i] = (cnt == '0);
        assign full[i]  = (cnt == depth_c);
        assign push     = wr[i] && !full[i];

        always_ff @(posedge clk) begin
            if (push)
                mem[wptr[aw-1:0]] <= in[i*psum_bw +: psum_bw];
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (push)
                    wptr <= wptr + one_c;
                if (pop)
                    rptr <= rptr + one_c;
            end
        end

        assign rd_row[i*psum_bw +: psum_bw] = mem[rptr[aw-1:0]];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            out <= '0;
        else if (pop)
            out <= rd_row;
    end

`ifdef OFIFO_OVF_FLAG_EN
    // Sticky until reset: dropped write on a full column or pop with no full row
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            o_overflow <= 1'b0;
        else if (|(wr & full) || (rd && !o_valid))
            o_overflow <= 1'b1;
    end
`endif

endmodule
